// File: rtl/ping_pong_ctrl_if.sv
// Producer write handshake and scan-side read port of the ping-pong double-buffer controller.
interface ping_pong_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
);
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/ping_pong_ctrl.sv
// Two-RAM double-buffer sequencer: the producer fills the back bank while the scan side reads
// the front bank; banks swap only at a frame boundary once the back bank is complete.
module ping_pong_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  ping_pong_ctrl_if.slave   bus,
  output logic              front_bank,
  output logic              frame_valid,
  output logic [7:0]        overrun_cnt,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic [DATA_W-1:0] ram0_wdata,
  output logic [DATA_W-1:0] ram1_wdata,
  output logic              ram0_wren,
  output logic              ram1_wren,
  input  logic [DATA_W-1:0] ram0_q,
  input  logic [DATA_W-1:0] ram1_q
);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_DONE = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_r;
  logic              front_bank_r;
  logic              frame_valid_r;
  logic [ADDR_W-1:0] wr_cnt_r;
  logic [7:0]        overrun_cnt_r;
  logic              rd_pend_r;
  logic              rd_bank_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] rd_data_r;

  logic              wr_ready_s;
  logic              xfer_s;
  logic              last_s;
  logic [ADDR_W-1:0] front_addr_s;
  logic [DATA_W-1:0] back_wdata_s;

  assign wr_ready_s = (state_r == ST_FILL);
  assign xfer_s     = bus.wr_valid && wr_ready_s;
  assign last_s     = xfer_s && (wr_cnt_r == LAST_ADDR);

  // Route the read port to the front bank and the write port to the back bank.
  always_comb begin
    front_addr_s = {ADDR_W{1'b0}};
    back_wdata_s = {DATA_W{1'b0}};
    ram0_addr    = {ADDR_W{1'b0}};
    ram1_addr    = {ADDR_W{1'b0}};
    ram0_wdata   = {DATA_W{1'b0}};
    ram1_wdata   = {DATA_W{1'b0}};
    ram0_wren    = 1'b0;
    ram1_wren    = 1'b0;
    if (bus.rd_en) begin
      front_addr_s = bus.rd_addr;
    end else begin
      front_addr_s = {ADDR_W{1'b0}};
    end
    if (xfer_s) begin
      back_wdata_s = bus.wr_data;
    end else begin
      back_wdata_s = {DATA_W{1'b0}};
    end
    if (front_bank_r == 1'b0) begin
      ram0_addr  = front_addr_s;
      ram1_addr  = wr_cnt_r;
      ram1_wdata = back_wdata_s;
      ram1_wren  = xfer_s;
    end else begin
      ram1_addr  = front_addr_s;
      ram0_addr  = wr_cnt_r;
      ram0_wdata = back_wdata_s;
      ram0_wren  = xfer_s;
    end
  end

  // Fill/done/swap sequencing, write counter, overrun count and bank selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_FILL;
      front_bank_r  <= 1'b0;
      frame_valid_r <= 1'b0;
      wr_cnt_r      <= {ADDR_W{1'b0}};
      overrun_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (last_s) begin
            state_r <= frame_start ? ST_SWAP : ST_DONE;
          end else if (xfer_s) begin
            wr_cnt_r <= wr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            wr_cnt_r <= wr_cnt_r;
          end
          // A frame boundary before the back bank is complete is an overrun.
          if (frame_start && !last_s && (overrun_cnt_r != 8'hFF)) begin
            overrun_cnt_r <= overrun_cnt_r + 8'd1;
          end else begin
            overrun_cnt_r <= overrun_cnt_r;
          end
        end
        ST_DONE: begin
          if (frame_start) begin
            state_r <= ST_SWAP;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_SWAP: begin
          front_bank_r  <= ~front_bank_r;
          wr_cnt_r      <= {ADDR_W{1'b0}};
          frame_valid_r <= 1'b1;
          state_r       <= ST_FILL;
        end
        default: begin
          state_r <= ST_FILL;
        end
      endcase
    end
  end

  // Read pipeline: remember which bank was addressed, then register its RAM output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {DATA_W{1'b0}};
    end else begin
      rd_pend_r  <= bus.rd_en;
      rd_bank_r  <= front_bank_r;
      rd_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rd_data_r <= rd_bank_r ? ram1_q : ram0_q;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  assign bus.wr_ready = wr_ready_s;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign front_bank   = front_bank_r;
  assign frame_valid  = frame_valid_r;
  assign overrun_cnt  = overrun_cnt_r;

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Scoreboard bench for ping_pong_ctrl: stimulus queues expected RAM writes and read data,
// a negedge monitor pops and compares whenever the DUT writes a RAM or presents rd_valid.
module tb_ping_pong_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 120;

  logic              clk;
  logic              reset;
  logic              frame_start;
  logic              front_bank;
  logic              frame_valid;
  logic [7:0]        overrun_cnt;
  logic [ADDR_W-1:0] ram0_addr, ram1_addr;
  logic [DATA_W-1:0] ram0_wdata, ram1_wdata;
  logic              ram0_wren, ram1_wren;
  logic [DATA_W-1:0] ram0_q, ram1_q;
  logic [DATA_W-1:0] mem0 [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mem1 [0:(1<<ADDR_W)-1];

  int checks;
  int failures;
  logic [15:0]       wr_q[$];
  logic [DATA_W-1:0] rd_q[$];

  ping_pong_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ping_pong_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bus         (bus),
    .front_bank  (front_bank),
    .frame_valid (frame_valid),
    .overrun_cnt (overrun_cnt),
    .ram0_addr   (ram0_addr),
    .ram1_addr   (ram1_addr),
    .ram0_wdata  (ram0_wdata),
    .ram1_wdata  (ram1_wdata),
    .ram0_wren   (ram0_wren),
    .ram1_wren   (ram1_wren),
    .ram0_q      (ram0_q),
    .ram1_q      (ram1_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs with one-cycle registered read.
  always @(posedge clk) begin
    if (ram0_wren) mem0[ram0_addr] <= ram0_wdata;
    if (ram1_wren) mem1[ram1_addr] <= ram1_wdata;
    ram0_q <= mem0[ram0_addr];
    ram1_q <= mem1[ram1_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every RAM write and every valid read must match the head of its queue.
  always @(negedge clk) begin
    logic [15:0] we;
    logic [DATA_W-1:0] re;
    chk("wren_exclusive", 32'(ram0_wren && ram1_wren), 32'd0);
    if (ram0_wren || ram1_wren) begin
      chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        if (ram0_wren) chk("wr_ram0", 32'({1'b0, ram0_addr, ram0_wdata}), 32'(we));
        else           chk("wr_ram1", 32'({1'b1, ram1_addr, ram1_wdata}), 32'(we));
      end
    end
    if (bus.rd_valid) begin
      chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(re));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int first, input int n, input int base, input int mult, input logic bank);
    for (int i = first; i < first + n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(base + mult * i);
      wr_q.push_back({bank, 7'(i), 8'(base + mult * i)});
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [7:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 7'(addr);
    rd_q.push_back(exp);
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_ready"},    32'(bus.wr_ready), 32'd1);
    chk({tag, "_front_bank"},  32'(front_bank), 32'd0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
    chk({tag, "_overrun"},     32'(overrun_cnt), 32'd0);
    chk({tag, "_rd_valid"},    32'(bus.rd_valid), 32'd0);
    chk({tag, "_rd_data"},     32'(bus.rd_data), 32'd0);
    chk({tag, "_ram_ports"},
        32'({ram0_addr, ram1_addr, ram0_wdata, ram1_wdata, ram0_wren, ram1_wren}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    frame_start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'd0;
    bus.rd_en = 1'b0;
    bus.rd_addr = 7'd0;
    step();
    step();
    check_reset_values("reset");
    reset = 1'b0;
    step();

    // Frame 1: values 0..119 into ram1, extra wr_valid cycle must not write.
    fill(0, DEPTH, 0, 1, 1'b1);
    bus.wr_valid = 1'b1;
    chk("done_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("done_frame_valid", 32'(frame_valid), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    bus.wr_valid = 1'b0;
    chk("swap_front_old", 32'(front_bank), 32'd0);
    chk("swap_wr_ready", 32'(bus.wr_ready), 32'd0);
    step();
    chk("swap1_front_new", 32'(front_bank), 32'd1);
    chk("swap1_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("swap1_frame_valid", 32'(frame_valid), 32'd1);
    rd(0, 8'd0);
    rd(5, 8'd5);
    rd(119, 8'd119);
    step();
    step();
    step();
    chk("reads1_drained", 32'(rd_q.size()), 32'd0);

    // Frame 2 into ram0 (values i+50) with an early frame_start after 60 entries.
    fill(0, 60, 50, 1, 1'b0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("overrun_one", 32'(overrun_cnt), 32'd1);
    chk("overrun_no_swap", 32'(front_bank), 32'd1);
    chk("overrun_wr_ready", 32'(bus.wr_ready), 32'd1);
    fill(60, 60, 50, 1, 1'b0);
    chk("fill2_done", 32'(bus.wr_ready), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("swap2_front", 32'(front_bank), 32'd0);
    rd(60, 8'd110);
    rd(119, 8'd169);
    step();
    step();
    step();

    // Frame 3 into ram1 (values 2*i); frame_start coincides with the final write.
    fill(0, DEPTH - 1, 0, 2, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd238;
    wr_q.push_back({1'b1, 7'd119, 8'd238});
    frame_start = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    frame_start = 1'b0;
    chk("coinc_swap_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("coinc_swap_front_old", 32'(front_bank), 32'd0);
    rd(3, 8'd53);
    chk("coinc_front_new", 32'(front_bank), 32'd1);
    chk("coinc_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("coinc_no_overrun", 32'(overrun_cnt), 32'd1);
    rd(3, 8'd6);
    step();
    step();
    step();
    chk("reads3_drained", 32'(rd_q.size()), 32'd0);

    // Partial frame into ram0, then reset with a read in flight (nothing queued for it).
    fill(0, 30, 7, 1, 1'b0);
    bus.rd_en = 1'b1;
    bus.rd_addr = 7'd10;
    step();
    bus.rd_en = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    step();
    step();
    reset = 1'b0;
    step();
    fill(0, DEPTH, 9, 1, 1'b1);
    chk("refill_done", 32'(bus.wr_ready), 32'd0);
    chk("refill_frame_valid", 32'(frame_valid), 32'd0);
    step();
    step();
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
